// File: rtl/bp_cacc_pkg.sv
// bp_cacc_pkg: shared definitions for the VDP job scheduler.
//   - CSR addresses of the vector-dot-product accelerator (20-bit local space)
//   - scheduler state encoding
//   - buffered job descriptor
//   - helper that maps a write-sequence step to its CSR address
package bp_cacc_pkg;

  localparam logic [19:0] csr_a_ptr_gp   = 20'h00000;
  localparam logic [19:0] csr_b_ptr_gp   = 20'h00040;
  localparam logic [19:0] csr_len_gp     = 20'h00080;
  localparam logic [19:0] csr_start_gp   = 20'h000c0;
  localparam logic [19:0] csr_status_gp  = 20'h00100;
  localparam logic [19:0] csr_res_ptr_gp = 20'h00140;
  localparam logic [19:0] csr_res_len_gp = 20'h00180;
  localparam logic [19:0] csr_op_gp      = 20'h00200;

  // Descriptor pointers are held already zero-extended to a full dword.
  localparam int ptr_width_gp = 64;

  // Index of the final (start) write in the programming sequence.
  localparam logic [2:0] wr_last_gp = 3'd6;

  typedef enum logic [2:0] {
    e_idle,
    e_check,
    e_wr,
    e_wr_resp,
    e_gap,
    e_poll,
    e_poll_resp,
    e_report
  } state_e;

  typedef struct packed {
    logic [ptr_width_gp-1:0] a_ptr;
    logic [ptr_width_gp-1:0] b_ptr;
    logic [ptr_width_gp-1:0] res_ptr;
    logic [3:0]              len;
  } desc_s;

  // Programming order: a_ptr, b_ptr, len, res_ptr, res_len, operation, start.
  // Start must stay last so the VDP never sees a half-programmed job.
  function automatic logic [19:0] wr_seq_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    wr_seq_addr = csr_a_ptr_gp;
      3'd1:    wr_seq_addr = csr_b_ptr_gp;
      3'd2:    wr_seq_addr = csr_len_gp;
      3'd3:    wr_seq_addr = csr_res_ptr_gp;
      3'd4:    wr_seq_addr = csr_res_len_gp;
      3'd5:    wr_seq_addr = csr_op_gp;
      default: wr_seq_addr = csr_start_gp;
    endcase
  endfunction

endpackage

// File: rtl/bp_cacc_rr_arb.sv
// bp_cacc_rr_arb: round-robin arbiter over the descriptor-slot full vector.
// Ports:
//   clk_i, reset_i  clock, synchronous active-high reset
//   req_i           request vector (one bit per slot)
//   yumi_i          grant taken; pointer moves to grant+1 (mod num_req_p)
//   grant_v_o       some request is present
//   grant_id_o      encoded grant (first request at or after the pointer)
//   grant_oh_o      one-hot form of grant_id_o
module bp_cacc_rr_arb
  import bp_cacc_pkg::*;
#(
  parameter int num_req_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_req_p-1:0]         req_i,
  input  logic                         yumi_i,
  output logic                         grant_v_o,
  output logic [$clog2(num_req_p)-1:0] grant_id_o,
  output logic [num_req_p-1:0]         grant_oh_o
);

  localparam int id_w_lp = $clog2(num_req_p);

  logic [id_w_lp-1:0] rr_ptr_reg;

  // (base + off) mod num_req_p, valid for off < num_req_p.
  function automatic logic [id_w_lp-1:0] wrap_add(input logic [id_w_lp-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= num_req_p) sum = sum - num_req_p;
    return id_w_lp'(sum);
  endfunction

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    grant_v_o  = 1'b0;
    grant_id_o = '0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      if (req_i[wrap_add(rr_ptr_reg, k)]) begin
        grant_v_o  = 1'b1;
        grant_id_o = wrap_add(rr_ptr_reg, k);
      end
    end
  end

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_oh
    assign grant_oh_o[gi] = grant_v_o & (grant_id_o == id_w_lp'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_reg <= '0;
    end else if (yumi_i & grant_v_o) begin
      rr_ptr_reg <= wrap_add(grant_id_o, 1);
    end
  end

endmodule

// File: rtl/bp_cacc_vdp_sched.sv
// bp_cacc_vdp_sched: shares one VDP between num_req_p requesters.
// Buffers one descriptor per requester, picks jobs round-robin, programs the
// VDP CSRs over the uncached IO channel, starts it, polls status, and pulses
// done to the owner.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_v_i / req_ready_o          per-requester descriptor handshake
//   req_a_ptr_i, req_b_ptr_i,
//   req_res_ptr_i, req_len_i       packed per-requester descriptor fields
//   done_v_o, done_id_o, done_err_o  one-cycle completion report
//   io_cmd_*                       CSR command (valid/ready)
//   io_resp_v_i, io_resp_data_i,
//   io_resp_yumi_o                 CSR response (valid/yumi)
//   busy_o                         a job is in flight
module bp_cacc_vdp_sched
  import bp_cacc_pkg::*;
#(
  parameter int num_req_p     = 4,
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  parameter int max_len_p     = 8,
  parameter int poll_gap_p    = 16,
  parameter int poll_limit_p  = 1024
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_req_p-1:0]               req_v_i,
  output logic [num_req_p-1:0]               req_ready_o,
  input  logic [num_req_p*paddr_width_p-1:0] req_a_ptr_i,
  input  logic [num_req_p*paddr_width_p-1:0] req_b_ptr_i,
  input  logic [num_req_p*paddr_width_p-1:0] req_res_ptr_i,
  input  logic [num_req_p*4-1:0]             req_len_i,
  output logic                               done_v_o,
  output logic [$clog2(num_req_p)-1:0]       done_id_o,
  output logic                               done_err_o,
  output logic                               io_cmd_v_o,
  output logic                               io_cmd_wr_o,
  output logic [19:0]                        io_cmd_addr_o,
  output logic [dword_width_p-1:0]           io_cmd_data_o,
  input  logic                               io_cmd_ready_i,
  input  logic                               io_resp_v_i,
  input  logic [dword_width_p-1:0]           io_resp_data_i,
  output logic                               io_resp_yumi_o,
  output logic                               busy_o
);

  localparam int id_w_lp   = $clog2(num_req_p);
  localparam int gap_w_lp  = $clog2(poll_gap_p + 1);
  localparam int poll_w_lp = $clog2(poll_limit_p + 1);

  logic [num_req_p-1:0] slot_full;
  logic [num_req_p-1:0] slot_free;
  desc_s                slot_desc [num_req_p];

  logic                 arb_v;
  logic [id_w_lp-1:0]   arb_id;
  logic [num_req_p-1:0] unused_arb_oh;
  logic                 arb_yumi;

  state_e               state_reg,    state_next;
  logic [id_w_lp-1:0]   cur_id_reg,   cur_id_next;
  logic [2:0]           wr_idx_reg,   wr_idx_next;
  logic [gap_w_lp-1:0]  gap_cnt_reg,  gap_cnt_next;
  logic [poll_w_lp-1:0] poll_cnt_reg, poll_cnt_next;
  logic                 err_reg,      err_next;

  desc_s                cur_desc;
  logic [63:0]          wr_data;

  // Only bit 0 of the status register carries meaning.
  logic unused_resp_bits;
  assign unused_resp_bits = ^io_resp_data_i[dword_width_p-1:1];

  // Held low during reset so every output reads 0 while reset_i is high.
  assign req_ready_o = ~slot_full & {num_req_p{~reset_i}};

  // Descriptor slots. A slot is never granted while in flight because
  // arbitration happens only in e_idle.
  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_slot
    logic  full_reg;
    desc_s desc_reg;

    assign slot_full[gi] = full_reg;
    assign slot_desc[gi] = desc_reg;
    assign slot_free[gi] = (state_reg == e_report) & (cur_id_reg == id_w_lp'(gi));

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        full_reg <= 1'b0;
        desc_reg <= '0;
      end else if (req_v_i[gi] & req_ready_o[gi]) begin
        full_reg         <= 1'b1;
        desc_reg.a_ptr   <= ptr_width_gp'(req_a_ptr_i[gi*paddr_width_p +: paddr_width_p]);
        desc_reg.b_ptr   <= ptr_width_gp'(req_b_ptr_i[gi*paddr_width_p +: paddr_width_p]);
        desc_reg.res_ptr <= ptr_width_gp'(req_res_ptr_i[gi*paddr_width_p +: paddr_width_p]);
        desc_reg.len     <= req_len_i[gi*4 +: 4];
      end else if (slot_free[gi]) begin
        full_reg <= 1'b0;
      end
    end
  end

  // Arbiter sees registered (pre-capture) slot state.
  bp_cacc_rr_arb #(
    .num_req_p (num_req_p)
  ) rr_arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (slot_full),
    .yumi_i     (arb_yumi),
    .grant_v_o  (arb_v),
    .grant_id_o (arb_id),
    .grant_oh_o (unused_arb_oh)
  );

  assign cur_desc = slot_desc[cur_id_reg];

  always_comb begin
    wr_data = '0;
    case (wr_idx_reg)
      3'd0:    wr_data = cur_desc.a_ptr;
      3'd1:    wr_data = cur_desc.b_ptr;
      3'd2:    wr_data = 64'(cur_desc.len);
      3'd3:    wr_data = cur_desc.res_ptr;
      3'd4:    wr_data = 64'd1;
      3'd5:    wr_data = 64'd0;
      default: wr_data = 64'd1;
    endcase
  end

  assign busy_o = (state_reg != e_idle);

  always_comb begin
    state_next     = state_reg;
    cur_id_next    = cur_id_reg;
    wr_idx_next    = wr_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    poll_cnt_next  = poll_cnt_reg;
    err_next       = err_reg;
    arb_yumi       = 1'b0;
    io_cmd_v_o     = 1'b0;
    io_cmd_wr_o    = 1'b0;
    io_cmd_addr_o  = '0;
    io_cmd_data_o  = '0;
    io_resp_yumi_o = 1'b0;
    done_v_o       = 1'b0;
    done_id_o      = '0;
    done_err_o     = 1'b0;

    case (state_reg)
      e_idle: begin
        if (arb_v) begin
          arb_yumi    = 1'b1;
          cur_id_next = arb_id;
          state_next  = e_check;
        end
      end
      e_check: begin
        // Bad lengths are rejected without touching the VDP.
        if ((cur_desc.len == 4'd0) || (int'(cur_desc.len) > max_len_p)) begin
          err_next   = 1'b1;
          state_next = e_report;
        end else begin
          err_next      = 1'b0;
          wr_idx_next   = '0;
          poll_cnt_next = '0;
          state_next    = e_wr;
        end
      end
      e_wr: begin
        io_cmd_v_o    = 1'b1;
        io_cmd_wr_o   = 1'b1;
        io_cmd_addr_o = wr_seq_addr(wr_idx_reg);
        io_cmd_data_o = dword_width_p'(wr_data);
        if (io_cmd_ready_i) state_next = e_wr_resp;
      end
      e_wr_resp: begin
        io_resp_yumi_o = io_resp_v_i;
        if (io_resp_v_i) begin
          if (wr_idx_reg == wr_last_gp) begin
            gap_cnt_next = '0;
            state_next   = e_gap;
          end else begin
            wr_idx_next = wr_idx_reg + 3'd1;
            state_next  = e_wr;
          end
        end
      end
      e_gap: begin
        gap_cnt_next = gap_cnt_reg + gap_w_lp'(1);
        if (gap_cnt_reg == gap_w_lp'(poll_gap_p - 1)) state_next = e_poll;
      end
      e_poll: begin
        io_cmd_v_o    = 1'b1;
        io_cmd_addr_o = csr_status_gp;
        if (io_cmd_ready_i) state_next = e_poll_resp;
      end
      e_poll_resp: begin
        io_resp_yumi_o = io_resp_v_i;
        if (io_resp_v_i) begin
          if (io_resp_data_i[0]) begin
            err_next   = 1'b0;
            state_next = e_report;
          end else begin
            poll_cnt_next = poll_cnt_reg + poll_w_lp'(1);
            gap_cnt_next  = '0;
            if (poll_cnt_next == poll_w_lp'(poll_limit_p)) begin
              err_next   = 1'b1;
              state_next = e_report;
            end else begin
              state_next = e_gap;
            end
          end
        end
      end
      e_report: begin
        done_v_o   = 1'b1;
        done_id_o  = cur_id_reg;
        done_err_o = err_reg;
        state_next = e_idle;
      end
      default: state_next = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg    <= e_idle;
      cur_id_reg   <= '0;
      wr_idx_reg   <= '0;
      gap_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_id_reg   <= cur_id_next;
      wr_idx_reg   <= wr_idx_next;
      gap_cnt_reg  <= gap_cnt_next;
      poll_cnt_reg <= poll_cnt_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: doc/bp_cacc_vdp_sched.md
Name: bp_cacc_vdp_sched

Overview:
Job scheduler sharing one vector-dot-product accelerator (VDP) between num_req_p requesters, e.g. cores or a DMA engine.
- Buffers one job descriptor per requester.
- Picks the next job round-robin.
- Programs the VDP's memory-mapped CSRs over an uncached IO command/response channel, starts the VDP, polls its status register until it completes, then pulses a completion to the owner.
- Sits between the requester fabric and the VDP io_cmd/io_resp ports, on the accelerator tile.

Parameters:
- num_req_p, 4, number of requesters (>=2).
- paddr_width_p, 40, physical pointer width.
- dword_width_p, 64, CSR data width.
- max_len_p, 8, maximum vector length supported by the VDP.
- poll_gap_p, 16, idle cycles between status polls.
- poll_limit_p, 1024, polls before a job is declared timed out.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- req_v_i  in  num_req_p  per-requester descriptor valid
- req_ready_o  out  num_req_p  per-requester descriptor slot free
- req_a_ptr_i  in  num_req_p*paddr_width_p  vector A base
- req_b_ptr_i  in  num_req_p*paddr_width_p  vector B base
- req_res_ptr_i  in  num_req_p*paddr_width_p  result address
- req_len_i  in  num_req_p*4  element count
- done_v_o  out  1  one-cycle completion pulse
- done_id_o  out  `BSG_SAFE_CLOG2(num_req_p)  requester index of the completed job
- done_err_o  out  1  job rejected or timed out
- io_cmd_v_o  out  1  CSR access valid
- io_cmd_wr_o  out  1  1 = uncached write, 0 = uncached read
- io_cmd_addr_o  out  20  VDP local CSR address
- io_cmd_data_o  out  dword_width_p  write data
- io_cmd_ready_i  in  1  VDP accepts the command
- io_resp_v_i  in  1  VDP response valid
- io_resp_data_i  in  dword_width_p  read data
- io_resp_yumi_o  out  1  response consumed
- busy_o  out  1  a job is in flight

Interface decision: one clock, clk_i; reset_i is synchronous and active-high.

Behaviour:
CSR map:
- 0x00000 a_ptr, 0x00040 b_ptr, 0x00080 len, 0x000c0 start.
- 0x00100 status (read), 0x00140 res_ptr, 0x00180 res_len, 0x00200 operation.

Reset values: all outputs 0, all slots empty, RR pointer 0, state IDLE. req_ready_o becomes 1 in the first cycle after reset deasserts.

Descriptor slots:
- A slot captures its descriptor when req_v_i & req_ready_o.
- req_ready_o = ~slot_full.
- The slot frees in the cycle its job issues done_v_o. It is refillable on the next cycle.

Arbitration:
- In IDLE, pick the first full slot at or after rr_ptr (wrapping).
- rr_ptr then becomes grant+1 mod num_req_p. Grant takes 1 cycle.

State machine:
- IDLE -> CHECK when any slot is full.
- CHECK: if len==0 or len>max_len_p, go to REPORT with err=1; the VDP is not touched. Otherwise go to WR.
- WR: step through the write sequence below. For each write, hold io_cmd_v_o until io_cmd_ready_i, then go to WR_RESP.
  - a_ptr
  - b_ptr
  - len
  - res_ptr
  - res_len=1
  - operation=0
  - start=1, always last
- WR_RESP: io_resp_yumi_o = io_resp_v_i (combinational). On the response, advance to the next write; after the start write, go to GAP.
- GAP: count poll_gap_p cycles, then go to POLL.
- POLL: issue a read of 0x00100, then go to POLL_RESP.
- POLL_RESP: on the response, status[0]==1 -> REPORT with err=0.
  - Otherwise increment poll_cnt. If poll_cnt reaches poll_limit_p -> REPORT with err=1; else -> GAP.
- REPORT: drive done_v_o=1, done_id_o and done_err_o for exactly 1 cycle, free the slot, return to IDLE.

Command channel rules:
- io_cmd_* outputs stay stable while io_cmd_v_o & ~io_cmd_ready_i.
- At most one outstanding command; no new command until the response is consumed.
- A response arriving outside WR_RESP/POLL_RESP is not acked.

Other rules:
- busy_o = state != IDLE.
- Pointers are zero-extended to dword_width_p.
- A requester whose slot is in flight is not re-granted.
- New descriptors from other requesters are accepted during a job.
- Same-cycle slot refill and grant: the grant decision uses pre-capture slot state.
- reset_i mid-job: abandon everything within 1 cycle. No done pulse, io_cmd_v_o drops.

Decomposition:
- Shared package bp_cacc_pkg: CSR address localparams, state enum, descriptor struct {a_ptr, b_ptr, res_ptr, len}.
- One sub-module: bp_cacc_rr_arb, a round-robin grant over the slot-full vector with one-hot and encoded outputs (bsg_arb_round_robin is acceptable).

Test Plan:
- Single job, requester 1 (a=0x8000_1000, b=0x8000_2000, res=0x8000_3000, len=8). Status returns 0 twice, then 1. Expect:
  - writes in order 0x00000, 0x00040, 0x00080, 0x00140, 0x00180, 0x00200, 0x000c0 with matching data;
  - 3 reads of 0x00100;
  - done_v_o pulse with id=1, err=0.
- All 4 requesters valid in the same cycle -> grant order 0,1,2,3. Then requester 0 resubmits while 3 runs -> it is served after 3.
- len=0 and len=9 -> done err=1, no io_cmd_v_o ever asserted.
- io_cmd_ready_i low for 5 cycles on the len write -> addr/data held constant; the sequence resumes intact.
- Status never 1, poll_limit_p=4 -> exactly 4 polls, then done err=1, slot freed.
- reset_i asserted in GAP -> next cycle all outputs 0, req_ready_o all 1 after release.
